timing_control: RTL and testbench
=================================

TIMING_CONTROL -- requirements
Module: timing_control

Interface
REQ-001 SHALL provide parameter EXTENDED_WRITE, default 0; when 1, the write strobe asserts one state early (S2 instead of S3).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port DREQ, input, 4, channel requests, active-high.
REQ-005 SHALL have port maskReg, input, 4; bit n=1 masks DREQ[n].
REQ-006 SHALL have port dmaDisable, input, 1; command-register controller disable.
REQ-007 SHALL have port blockMode, input, 1; 0=single transfer, 1=block transfer.
REQ-008 SHALL have port transferType, input, 2; 00=verify, 01=write (IOR_n+MEMW_n), 10=read (MEMR_n+IOW_n), 11=illegal, treated as verify.
REQ-009 SHALL have port HLDA, input, 1, hold acknowledge from CPU.
REQ-010 SHALL have port READY, input, 1; low in S3 inserts wait states.
REQ-011 SHALL have port TC, input, 1; terminal count from the count register, valid in S4.
REQ-012 SHALL have port EOP_n, input, 1, external end-of-process, active-low.
REQ-013 SHALL have port HRQ, output, 1, hold request to CPU.
REQ-014 SHALL have port AEN, output, 1, address enable.
REQ-015 SHALL have port ADSTB, output, 1, upper-address strobe.
REQ-016 SHALL have port assertDACK, output, 1; enables DACK generation in the downstream priority logic.
REQ-017 SHALL have ports MEMR_n, MEMW_n, IOR_n, IOW_n, outputs, 1 each, active-low strobes.
REQ-018 SHALL have port addrStep, output, 1, one-cycle pulse commanding address increment/decrement and count decrement.

Function
REQ-019 SHALL define reqValid = |(DREQ & ~maskReg) & ~dmaDisable.
REQ-020 SHALL implement the states SI, S0, S1, S2, S3, SW and S4, registered and Moore-decoded except for addrStep.
REQ-021 SI: all outputs inactive; reqValid=1 -> S0 next cycle.
REQ-022 S0: HRQ=1; HLDA=1 -> S1; HLDA=0 -> stay S0; reqValid=0 while HLDA=0 -> SI with HRQ dropped.
REQ-023 S1: HRQ, AEN, ADSTB and assertDACK=1; -> S2 unconditionally.
REQ-024 S2: ADSTB=0; AEN, assertDACK and HRQ held; read strobe low (MEMR_n for read, IOR_n for write); write strobe low here if EXTENDED_WRITE=1; -> S3.
REQ-025 S3: read strobe and write strobe (MEMW_n for write, IOW_n for read) low; READY=0 -> SW, READY=1 -> S4.
REQ-026 SW: outputs identical to S3; stay while READY=0; READY=1 -> S4.
REQ-027 S4: all strobes high; addrStep=1 for exactly this cycle; AEN and assertDACK still 1.
REQ-028 S4 exit when TC=1, or EOP_n was seen low at any cycle since S1, or blockMode=0: -> SI with HRQ, AEN and assertDACK low in SI.
REQ-029 S4 exit in block mode with no termination: -> S1 if reqValid=1, else -> SI.
REQ-030 SHALL register EOP_n low in a sticky flag set in S1..S4 and cleared on entry to SI; EOP_n SHALL be ignored in SI and S0.
REQ-031 SHALL assert no strobe in any state for verify (or 11) transfers; state sequencing SHALL be unchanged.
REQ-032 SHALL ignore HLDA deassertion in S1..S4, completing the transfer to S4 first.
REQ-033 SHALL never drive a read strobe and a write strobe for the same resource (MEMR_n/MEMW_n, IOR_n/IOW_n) low in the same cycle.
REQ-034 assertDACK SHALL be 1 exactly in S1, S2, S3, SW and S4.
REQ-035 SHALL sample dmaDisable and maskReg changes during S1..S4 only at the S4 exit decision.

Reset
REQ-036 RESET=1 at a clock edge SHALL force SI next cycle from any state, including mid-transfer.
REQ-037 After reset, HRQ, AEN, ADSTB, assertDACK and addrStep SHALL be 0, all strobes SHALL be 1, and the EOP flag SHALL be cleared.
REQ-038 SHALL apply RESET priority over all other inputs.

Verification
REQ-039 Single read: DREQ=0001, mask=0, HLDA tied 1 from S0, READY=1 -> SI,S0,S1,S2,S3,S4,SI; MEMR_n low in S2-S3; IOW_n low in S3; addrStep one pulse.
REQ-040 Wait states: write transfer, READY=0 for 3 cycles in S3 -> three SW cycles with IOR_n and MEMW_n held low, then S4.
REQ-041 Block mode, TC=1 on the third S4 -> three S1..S4 loops, three addrStep pulses, then SI with HRQ=0.
REQ-042 EOP_n pulsed low during S2 of a block transfer -> the current transfer completes, then SI after S4.
REQ-043 DREQ=0100 with maskReg=0100, or dmaDisable=1 -> state stays SI and HRQ stays 0.
REQ-044 RESET asserted in SW -> next cycle SI with all strobes high and assertDACK=0.

Source files
------------

// File: rtl/timing_control.sv
// -----------------------------------------------------------------------------
// timing_control
//
// This is the DMA transfer timing sequencer. It requests the bus from the CPU.
// Once the bus is granted it steps through the address, read-strobe,
// write-strobe and end states for each transfer. In block mode it loops back
// to the address state until a transfer terminates.
//
// Parameters
//   EXTENDED_WRITE : 1 asserts the write strobe in S2 rather than S3.
//
// Ports
//   CLK          in   clock; all state changes on its rising edge
//   RESET        in   synchronous, active-high
//   DREQ[3:0]    in   channel requests, active-high
//   maskReg[3:0] in   bit n = 1 masks DREQ[n]
//   dmaDisable   in   controller disable from the command register
//   blockMode    in   0 = single transfer, 1 = block transfer
//   transferType in   00 verify, 01 write (IOR_n+MEMW_n), 10 read (MEMR_n+IOW_n),
//                     11 treated as verify
//   HLDA         in   hold acknowledge from the CPU
//   READY        in   low in S3/SW stretches the transfer with wait states
//   TC           in   terminal count, valid in S4
//   EOP_n        in   external end-of-process, active-low
//   HRQ          out  hold request
//   AEN          out  address enable
//   ADSTB        out  upper-address strobe
//   assertDACK   out  DACK enable for the priority logic
//   MEMR_n, MEMW_n, IOR_n, IOW_n  out  active-low bus strobes
//   addrStep     out  one-cycle pulse in S4 (address step + count decrement)
// -----------------------------------------------------------------------------
module timing_control #(
    parameter bit EXTENDED_WRITE = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [3:0] maskReg,
    input  logic       dmaDisable,
    input  logic       blockMode,
    input  logic [1:0] transferType,
    input  logic       HLDA,
    input  logic       READY,
    input  logic       TC,
    input  logic       EOP_n,
    output logic       HRQ,
    output logic       AEN,
    output logic       ADSTB,
    output logic       assertDACK,
    output logic       MEMR_n,
    output logic       MEMW_n,
    output logic       IOR_n,
    output logic       IOW_n,
    output logic       addrStep
);

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_SW = 3'd5,
        ST_S4 = 3'd6
    } state_t;

    // Output bundle, registered alongside the state.
    typedef struct packed {
        logic hrq;
        logic aen;
        logic adstb;
        logic dack;
        logic step;
        logic memr_n;
        logic memw_n;
        logic ior_n;
        logic iow_n;
    } ctl_t;

    state_t state;
    state_t state_nxt;
    ctl_t   ctl;
    logic   eop_seen;
    logic   req_valid;
    logic   in_xfer;
    logic   terminate;

    assign req_valid = (|(DREQ & ~maskReg)) & ~dmaDisable;

    // S1..S4 including wait states: the window in which EOP_n is observed.
    assign in_xfer = (state == ST_S1) || (state == ST_S2) || (state == ST_S3) ||
                     (state == ST_SW) || (state == ST_S4);

    // The S4 exit counts an EOP_n that is low in the S4 cycle itself as well
    // as one captured earlier in the transfer.
    assign terminate = TC | eop_seen | ~EOP_n | ~blockMode;

    // Moore decode of the outputs for a given state. Strobes follow the
    // transfer type. Verify and the illegal 11 code keep all strobes high,
    // so the sequencing does not depend on the type.
    function automatic ctl_t decode(input state_t s, input logic [1:0] tt);
        ctl_t c;
        logic rd_low;
        logic wr_low;
        c        = '0;
        c.memr_n = 1'b1;
        c.memw_n = 1'b1;
        c.ior_n  = 1'b1;
        c.iow_n  = 1'b1;

        c.hrq   = (s != ST_SI);
        c.aen   = (s == ST_S1) || (s == ST_S2) || (s == ST_S3) ||
                  (s == ST_SW) || (s == ST_S4);
        c.dack  = c.aen;
        c.adstb = (s == ST_S1);
        c.step  = (s == ST_S4);

        rd_low = (s == ST_S2) || (s == ST_S3) || (s == ST_SW);
        wr_low = (s == ST_S3) || (s == ST_SW) || (EXTENDED_WRITE && (s == ST_S2));

        // Read and write strobes always target different resources, so a
        // resource never sees its read and write strobe low together.
        case (tt)
            2'b01: begin
                c.ior_n  = ~rd_low;
                c.memw_n = ~wr_low;
            end
            2'b10: begin
                c.memr_n = ~rd_low;
                c.iow_n  = ~wr_low;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state logic. Mask and disable changes made mid-transfer only
    // matter at the S4 decision, because req_valid is not consulted in S1..SW.
    // HLDA is likewise only consulted in S0.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SI: if (req_valid) state_nxt = ST_S0;
            ST_S0: begin
                if (HLDA)            state_nxt = ST_S1;
                else if (!req_valid) state_nxt = ST_SI;
            end
            ST_S1: state_nxt = ST_S2;
            ST_S2: state_nxt = ST_S3;
            ST_S3,
            ST_SW: state_nxt = READY ? ST_S4 : ST_SW;
            ST_S4: state_nxt = (terminate || !req_valid) ? ST_SI : ST_S1;
            default: state_nxt = ST_SI;
        endcase
    end

    // State, sticky EOP flag and registered outputs. The outputs are decoded
    // from the next state, so they change on the same edge as the state and
    // there is no decode glitch on the strobes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_SI;
            ctl      <= decode(ST_SI, 2'b00);
            eop_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            ctl   <= decode(state_nxt, transferType);
            if (state_nxt == ST_SI)
                eop_seen <= 1'b0;
            else if (in_xfer && !EOP_n)
                eop_seen <= 1'b1;
        end
    end

    assign HRQ        = ctl.hrq;
    assign AEN        = ctl.aen;
    assign ADSTB      = ctl.adstb;
    assign assertDACK = ctl.dack;
    assign addrStep   = ctl.step;
    assign MEMR_n     = ctl.memr_n;
    assign MEMW_n     = ctl.memw_n;
    assign IOR_n      = ctl.ior_n;
    assign IOW_n      = ctl.iow_n;

endmodule

// File: tb/tb_timing_control.sv
// -----------------------------------------------------------------------------
// tb_timing_control
//
// Two copies of the sequencer, one with EXTENDED_WRITE=0 and one with
// EXTENDED_WRITE=1, receive the same inputs. A phase-level reference model
// predicts every output of both copies every cycle. Directed scenarios come
// first, then randomized episodes.
// -----------------------------------------------------------------------------
module tb_timing_control;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET;
    logic [3:0] DREQ, maskReg;
    logic       dmaDisable, blockMode;
    logic [1:0] transferType;
    logic       HLDA, READY, TC, EOP_n;

    logic HRQ0, AEN0, ADSTB0, DACK0, MEMR0, MEMW0, IOR0, IOW0, STEP0;
    logic HRQ1, AEN1, ADSTB1, DACK1, MEMR1, MEMW1, IOR1, IOW1, STEP1;

    timing_control #(.EXTENDED_WRITE(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
        .dmaDisable(dmaDisable), .blockMode(blockMode), .transferType(transferType),
        .HLDA(HLDA), .READY(READY), .TC(TC), .EOP_n(EOP_n),
        .HRQ(HRQ0), .AEN(AEN0), .ADSTB(ADSTB0), .assertDACK(DACK0),
        .MEMR_n(MEMR0), .MEMW_n(MEMW0), .IOR_n(IOR0), .IOW_n(IOW0), .addrStep(STEP0)
    );

    timing_control #(.EXTENDED_WRITE(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg),
        .dmaDisable(dmaDisable), .blockMode(blockMode), .transferType(transferType),
        .HLDA(HLDA), .READY(READY), .TC(TC), .EOP_n(EOP_n),
        .HRQ(HRQ1), .AEN(AEN1), .ADSTB(ADSTB1), .assertDACK(DACK1),
        .MEMR_n(MEMR1), .MEMW_n(MEMW1), .IOR_n(IOR1), .IOW_n(IOW1), .addrStep(STEP1)
    );

    logic [8:0] o0, o1;
    assign o0 = {HRQ0, AEN0, ADSTB0, DACK0, STEP0, MEMR0, MEMW0, IOR0, IOW0};
    assign o1 = {HRQ1, AEN1, ADSTB1, DACK1, STEP1, MEMR1, MEMW1, IOR1, IOW1};

    // Reference model: the bus-cycle phase a transfer is in.
    typedef enum int {P_IDLE, P_REQ, P_ADDR, P_RD, P_WR, P_WAIT, P_END} ph_t;
    ph_t ph = P_IDLE;
    bit  eop_mem = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int steps   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs in o0/o1 bit order for a phase, type and write timing.
    function automatic logic [8:0] exp_out(input ph_t p, input logic [1:0] tt, input bit ext);
        logic hrq, own, adstb, step, rd_low, wr_low, memr, memw, ior, iow;
        hrq    = (p != P_IDLE);
        own    = !(p inside {P_IDLE, P_REQ});
        adstb  = (p == P_ADDR);
        step   = (p == P_END);
        rd_low = p inside {P_RD, P_WR, P_WAIT};
        wr_low = (p inside {P_WR, P_WAIT}) || (ext && p == P_RD);
        memr = 1'b1; memw = 1'b1; ior = 1'b1; iow = 1'b1;
        if (tt == 2'b10) begin
            memr = !rd_low; iow = !wr_low;
        end else if (tt == 2'b01) begin
            ior = !rd_low; memw = !wr_low;
        end
        return {hrq, own, adstb, own, step, memr, memw, ior, iow};
    endfunction

    task automatic model_step();
        bit  rv;
        ph_t nx;
        rv = (|(DREQ & ~maskReg)) && !dmaDisable;
        nx = ph;
        if (RESET) begin
            ph = P_IDLE;
            eop_mem = 1'b0;
            return;
        end
        case (ph)
            P_IDLE: if (rv) nx = P_REQ;
            P_REQ:  if (HLDA) nx = P_ADDR; else if (!rv) nx = P_IDLE;
            P_ADDR: nx = P_RD;
            P_RD:   nx = P_WR;
            P_WR, P_WAIT: nx = READY ? P_END : P_WAIT;
            P_END:  nx = (TC || eop_mem || !EOP_n || !blockMode || !rv) ? P_IDLE : P_ADDR;
            default: nx = P_IDLE;
        endcase
        if (nx == P_IDLE)
            eop_mem = 1'b0;
        else if (!(ph inside {P_IDLE, P_REQ}) && !EOP_n)
            eop_mem = 1'b1;
        ph = nx;
    endtask

    // One clock: advance the model at the edge, check both copies 1 ns later,
    // and return at the falling edge so the caller can drive new inputs.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        chk("outs_ext0", {23'd0, o0}, {23'd0, exp_out(ph, transferType, 1'b0)});
        chk("outs_ext1", {23'd0, o1}, {23'd0, exp_out(ph, transferType, 1'b1)});
        if (STEP0 === 1'b1) steps++;
        @(negedge CLK);
    endtask

    task automatic quiet_inputs();
        DREQ = 4'h0; maskReg = 4'h0; dmaDisable = 1'b0; blockMode = 1'b0;
        HLDA = 1'b1; READY = 1'b1; TC = 1'b0; EOP_n = 1'b1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    int ends;
    int low_cycles;
    bit was_busy;

    initial begin
        RESET = 1'b1;
        transferType = 2'b10;
        quiet_inputs();
        @(negedge CLK);
        do_reset();

        // Single read transfer: one pass SI..S4 and a single address step.
        DREQ = 4'b0001; steps = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("single_rd_steps", steps, 1);
        chk("single_rd_hrq_off", {31'd0, HRQ0}, 32'd0);

        // Write transfer with three wait states.
        transferType = 2'b01; quiet_inputs(); do_reset();
        DREQ = 4'b0001; low_cycles = 0;
        for (int i = 0; i < 4; i++) tick();       // S0, S1, S2, S3
        if (MEMW0 === 1'b0 && IOR0 === 1'b0) low_cycles++;
        READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();                               // SW x3
            if (MEMW0 === 1'b0 && IOR0 === 1'b0) low_cycles++;
        end
        READY = 1'b1; DREQ = 4'b0000;
        tick();                                   // S4
        chk("wait_strobe_cycles", low_cycles, 4);
        chk("wait_s4_step", {31'd0, STEP0}, 32'd1);
        tick();

        // Block mode terminated by TC on the third S4.
        transferType = 2'b10; quiet_inputs(); do_reset();
        DREQ = 4'b0010; blockMode = 1'b1; ends = 0; steps = 0;
        for (int i = 0; i < 40; i++) begin
            TC = (ph == P_END && ends == 3);
            tick();
            if (ph == P_END) ends++;
            if (ends == 3 && ph == P_IDLE) break;
        end
        chk("block_tc_steps", steps, 3);
        chk("block_tc_hrq", {31'd0, HRQ0}, 32'd0);

        // EOP_n pulsed low in S2 of a block transfer ends it after S4.
        TC = 1'b0; quiet_inputs(); do_reset();
        DREQ = 4'b1000; blockMode = 1'b1; steps = 0; was_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            EOP_n = !(ph == P_RD);
            tick();
            if (ph != P_IDLE) was_busy = 1'b1;
            if (was_busy && ph == P_IDLE) break;
        end
        EOP_n = 1'b1;
        chk("eop_steps", steps, 1);
        chk("eop_aen", {31'd0, AEN0}, 32'd0);

        // Masked request and controller disable keep the sequencer idle.
        quiet_inputs(); do_reset();
        DREQ = 4'b0100; maskReg = 4'b0100;
        for (int i = 0; i < 5; i++) tick();
        chk("masked_hrq", {31'd0, HRQ0}, 32'd0);
        DREQ = 4'b1111; maskReg = 4'b0000; dmaDisable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("disabled_hrq", {31'd0, HRQ0}, 32'd0);

        // Reset in a wait state.
        transferType = 2'b01; quiet_inputs(); do_reset();
        DREQ = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        READY = 1'b0;
        tick();                                   // SW
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_sw_dack", {31'd0, DACK0}, 32'd0);
        chk("rst_sw_strobes", {28'd0, MEMR0, MEMW0, IOR0, IOW0}, 32'hF);

        // Randomized episodes.
        for (int ep = 0; ep < 40; ep++) begin
            transferType = 2'($urandom());
            quiet_inputs();
            do_reset();
            for (int c = 0; c < 75; c++) begin
                DREQ       = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom());
                maskReg    = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
                dmaDisable = ($urandom_range(0, 15) == 0);
                blockMode  = ($urandom_range(0, 3) != 0);
                HLDA       = ($urandom_range(0, 3) != 0);
                READY      = ($urandom_range(0, 2) != 0);
                TC         = ($urandom_range(0, 5) == 0);
                EOP_n      = ($urandom_range(0, 11) != 0);
                RESET      = ($urandom_range(0, 99) == 0);
                tick();
            end
            RESET = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
